// File: rtl/tdm_pkg.sv
// Shared constants, channel index type and FSM state encoding for the
// TDM frame assembler.
package tdm_pkg;

    localparam int TDM_NUM_CHANNELS = 4;
    localparam int TDM_DATA_WIDTH   = 16;

    typedef logic [$clog2(TDM_NUM_CHANNELS)-1:0] ch_idx_t;

    typedef enum logic {
        SEEK = 1'b0,
        FILL = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_frame_assembler_if.sv
// Serial sample input / parallel frame output bundle of the TDM assembler.
// TDM_ALIGN_CHECK_EN adds the sticky align_err status signal.
interface tdm_frame_assembler_if
    import tdm_pkg::*;
#(
    parameter int NUM_CHANNELS = TDM_NUM_CHANNELS,
    parameter int DATA_WIDTH   = TDM_DATA_WIDTH
);

    logic                                   in_valid;
    logic                                   in_sof;
    logic [DATA_WIDTH-1:0]                  in_data;
    logic                                   out_valid;
    logic                                   out_ready;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] out_data;
    logic                                   overflow;
`ifdef TDM_ALIGN_CHECK_EN
    logic                                   align_err;
`endif

    modport master (
        output in_valid,
        output in_sof,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  overflow
`ifdef TDM_ALIGN_CHECK_EN
        ,
        input  align_err
`endif
    );

    modport slave (
        input  in_valid,
        input  in_sof,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data,
        output overflow
`ifdef TDM_ALIGN_CHECK_EN
        ,
        output align_err
`endif
    );

endinterface

// File: rtl/tdm_chan_counter.sv
// Wrapping TDM channel index. A clear and an increment in the same cycle
// yield index 1, which is exactly what a start-of-frame sample needs.
module tdm_chan_counter
    import tdm_pkg::*;
#(
    parameter int NUM_CHANNELS = TDM_NUM_CHANNELS
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_inc,
    input  logic                            i_clr,
    output logic [$clog2(NUM_CHANNELS)-1:0] o_idx,
    output logic                            o_last
);

    localparam int CW = $clog2(NUM_CHANNELS);
    localparam logic [CW-1:0] LAST = CW'(NUM_CHANNELS - 1);

    logic [CW-1:0] r_idx;
    logic [CW-1:0] w_base;
    logic [CW-1:0] w_next;

    always_comb begin
        w_base = i_clr ? '0 : r_idx;
        w_next = w_base;
        if (i_inc) begin
            w_next = (w_base == LAST) ? '0 : w_base + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx <= '0;
        end else begin
            r_idx <= w_next;
        end
    end

    assign o_idx  = r_idx;
    assign o_last = (r_idx == LAST);

endmodule

// File: rtl/tdm_frame_assembler.sv
// Collects serialized TDM samples into a parallel frame with a one-deep
// output register. TDM_ALIGN_CHECK_EN adds a sticky align_err flag.
module tdm_frame_assembler
    import tdm_pkg::*;
#(
    parameter int NUM_CHANNELS = TDM_NUM_CHANNELS,
    parameter int DATA_WIDTH   = TDM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    tdm_frame_assembler_if.slave  bus
);

    localparam int CW = $clog2(NUM_CHANNELS);

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0] w_idx;
    logic [CW-1:0] w_wr_idx;
    logic          w_last;
    logic          w_sof;
    logic          w_accept;
    logic          w_complete;

    // The last slot is never buffered: it comes straight from in_data.
    logic [NUM_CHANNELS-2:0][DATA_WIDTH-1:0] r_buf;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] w_frame;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] r_out_data;
    logic                                   r_out_valid;
    logic                                   r_overflow;

    tdm_chan_counter #(
        .NUM_CHANNELS (NUM_CHANNELS)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_inc  (w_accept),
        .i_clr  (w_sof),
        .o_idx  (w_idx),
        .o_last (w_last)
    );

    always_comb begin
        w_sof       = bus.in_valid & bus.in_sof;
        w_accept    = bus.in_valid & ((r_state == FILL) | bus.in_sof);
        w_wr_idx    = w_sof ? '0 : w_idx;
        w_complete  = w_accept & ~bus.in_sof & w_last;
        w_state_nxt = r_state;
        if (w_sof) begin
            w_state_nxt = FILL;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= SEEK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_buf <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS - 1; i++) begin
                if (w_accept && (w_wr_idx == CW'(i))) begin
                    r_buf[i] <= bus.in_data;
                end
            end
        end
    end

    assign w_frame = {bus.in_data, r_buf};

    // A completed frame only replaces the held one if the consumer frees it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_complete) begin
            if (!r_out_valid || bus.out_ready) begin
                r_out_data  <= w_frame;
                r_out_valid <= 1'b1;
            end else begin
                r_overflow  <= 1'b1;
            end
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.overflow  = r_overflow;

`ifdef TDM_ALIGN_CHECK_EN
    logic w_restart;
    logic r_align_err;

    assign w_restart = w_sof & (r_state == FILL) & (w_idx != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_align_err <= 1'b0;
        end else if (w_restart) begin
            r_align_err <= 1'b1;
        end
    end

    assign bus.align_err = r_align_err;
`endif

endmodule

// File: tb/tb_tdm_frame_assembler.sv
// Scoreboard bench for tdm_frame_assembler with 4 channels of 16 bits;
// expected frames are queued by the stimulus and popped on each handshake.
module tb_tdm_frame_assembler;

    localparam int NC = 4;
    localparam int DW = 16;

    typedef logic [NC-1:0][DW-1:0] frame_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    tdm_frame_assembler_if #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW)) bus ();

    tdm_frame_assembler #(
        .NUM_CHANNELS (NC),
        .DATA_WIDTH   (DW)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_errors = 0;
    frame_t exp_q[$];
    frame_t m_exp;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic frame_t mk(logic [15:0] s0, logic [15:0] s1,
                                  logic [15:0] s2, logic [15:0] s3);
        frame_t f;
        f[0] = s0;
        f[1] = s1;
        f[2] = s2;
        f[3] = s3;
        return f;
    endfunction

    task automatic send(logic [15:0] d, logic sof);
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_data  = d;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic send_frame(logic [15:0] s0, logic [15:0] s1,
                              logic [15:0] s2, logic [15:0] s3);
        send(s0, 1'b1);
        send(s1, 1'b0);
        send(s2, 1'b0);
        send(s3, 1'b0);
    endtask

    // Each negedge with valid&ready precedes exactly one accepting edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_unexpected: got %h expected none",
                             bus.out_data);
                end else begin
                    m_exp = exp_q.pop_front();
                    check("sb_frame", bus.out_data, m_exp);
                end
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #3;
        reset = 1'b0;
        #1;
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_data", bus.out_data, 64'h0);
        check("rst_ovf", bus.overflow, 1'b0);
`ifdef TDM_ALIGN_CHECK_EN
        check("rst_align", bus.align_err, 1'b0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Basic frame, then a back-to-back frame with sof at index 0
        send(16'h0011, 1'b1);
        send(16'h0022, 1'b0);
        send(16'h0033, 1'b0);
        check("t1_valid_early", bus.out_valid, 1'b0);
        exp_q.push_back(mk(16'h0011, 16'h0022, 16'h0033, 16'h0044));
        send(16'h0044, 1'b0);
        check("t1_valid", bus.out_valid, 1'b1);
        check("t1_ovf", bus.overflow, 1'b0);
        exp_q.push_back(mk(16'h0055, 16'h0066, 16'h0077, 16'h0088));
        send_frame(16'h0055, 16'h0066, 16'h0077, 16'h0088);
        check("t1b_valid", bus.out_valid, 1'b1);
`ifdef TDM_ALIGN_CHECK_EN
        check("t1b_align", bus.align_err, 1'b0);
`endif
        idle(2);
        check("t1_clear", bus.out_valid, 1'b0);

        // Samples before any sof are discarded
        do_reset();
        send(16'h00AA, 1'b0);
        send(16'h00BB, 1'b0);
        idle(1);
        check("t2_seek", bus.out_valid, 1'b0);
        exp_q.push_back(mk(16'h0001, 16'h0002, 16'h0003, 16'h0004));
        send_frame(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        check("t2_valid", bus.out_valid, 1'b1);
        idle(2);

        // Backpressure: second frame dropped, overflow sticky
        do_reset();
        bus.out_ready = 1'b0;
        exp_q.push_back(mk(16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3));
        send_frame(16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3);
        send(16'h00B0, 1'b0);
        send(16'h00B1, 1'b0);
        send(16'h00B2, 1'b0);
        send(16'h00B3, 1'b0);
        check("t3_valid", bus.out_valid, 1'b1);
        check("t3_ovf", bus.overflow, 1'b1);
        check("t3_held", bus.out_data,
              mk(16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3));
        idle(3);
        check("t3_hold", bus.out_data,
              mk(16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3));
        bus.out_ready = 1'b1;
        idle(2);
        check("t3_drain", bus.out_valid, 1'b0);
        check("t3_sticky", bus.overflow, 1'b1);

        // Completion coinciding with a handshake replaces the frame
        do_reset();
        check("t3c_ovf_rst", bus.overflow, 1'b0);
        bus.out_ready = 1'b0;
        exp_q.push_back(mk(16'h00C0, 16'h00C1, 16'h00C2, 16'h00C3));
        send_frame(16'h00C0, 16'h00C1, 16'h00C2, 16'h00C3);
        send(16'h00D0, 1'b1);
        send(16'h00D1, 1'b0);
        send(16'h00D2, 1'b0);
        bus.out_ready = 1'b1;
        exp_q.push_back(mk(16'h00D0, 16'h00D1, 16'h00D2, 16'h00D3));
        send(16'h00D3, 1'b0);
        check("t3c_valid", bus.out_valid, 1'b1);
        check("t3c_data", bus.out_data,
              mk(16'h00D0, 16'h00D1, 16'h00D2, 16'h00D3));
        check("t3c_ovf", bus.overflow, 1'b0);
        idle(2);
        check("t3c_clear", bus.out_valid, 1'b0);

        // Early sof discards a partial frame
        do_reset();
        send(16'h0001, 1'b1);
        send(16'h0002, 1'b0);
`ifdef TDM_ALIGN_CHECK_EN
        check("t4_align_pre", bus.align_err, 1'b0);
`endif
        send(16'h0010, 1'b1);
`ifdef TDM_ALIGN_CHECK_EN
        check("t4_align", bus.align_err, 1'b1);
`endif
        exp_q.push_back(mk(16'h0010, 16'h0020, 16'h0030, 16'h0040));
        send(16'h0020, 1'b0);
        send(16'h0030, 1'b0);
        check("t4_partial", bus.out_valid, 1'b0);
        send(16'h0040, 1'b0);
        check("t4_valid", bus.out_valid, 1'b1);
        idle(2);

        // Bubbles inside a frame, then reset mid-frame
        do_reset();
        exp_q.push_back(mk(16'h1001, 16'h1002, 16'h1003, 16'h1004));
        send(16'h1001, 1'b1);
        idle(2);
        send(16'h1002, 1'b0);
        idle(1);
        send(16'h1003, 1'b0);
        idle(3);
        check("t5_bubble", bus.out_valid, 1'b0);
        send(16'h1004, 1'b0);
        check("t5_valid", bus.out_valid, 1'b1);
        idle(2);
        send(16'h2001, 1'b1);
        send(16'h2002, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("t5_rst_valid", bus.out_valid, 1'b0);
        check("t5_rst_data", bus.out_data, 64'h0);
        check("t5_rst_ovf", bus.overflow, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        send(16'h2003, 1'b0);
        send(16'h2004, 1'b0);
        idle(1);
        check("t5_seek", bus.out_valid, 1'b0);
        exp_q.push_back(mk(16'h3001, 16'h3002, 16'h3003, 16'h3004));
        send_frame(16'h3001, 16'h3002, 16'h3003, 16'h3004);
        check("t5_valid2", bus.out_valid, 1'b1);
        idle(3);

        check("sb_drain", 64'(exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tdm_frame_assembler.md
TDM_FRAME_ASSEMBLER -- requirements
Module: tdm_frame_assembler

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, number of TDM slots per frame (>=2).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, sample width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, the serialized sample is valid this cycle.
REQ-006 SHALL have port in_sof, input, 1, start of frame; qualified by in_valid, marks channel 0.
REQ-007 SHALL have port in_data, input, DATA_WIDTH, the serialized TDM sample.
REQ-008 SHALL have port out_valid, output, 1, an assembled frame is presented.
REQ-009 SHALL have port out_ready, input, 1, the consumer accepts the frame when out_valid is high.
REQ-010 SHALL have port out_data, output, NUM_CHANNELS x DATA_WIDTH, the parallel frame; slot k holds channel k.
REQ-011 SHALL have port overflow, output, 1, sticky flag: a completed frame was dropped.

Function
REQ-012 SHALL use FSM states SEEK (discard input until in_valid&in_sof) and FILL (accept samples).
REQ-013 SEEK->FILL SHALL occur on in_valid&in_sof; that sample is written to slot 0 and ch_idx becomes 1.
REQ-014 In FILL, each in_valid sample SHALL be written to slot ch_idx, then ch_idx SHALL increment, wrapping NUM_CHANNELS-1 -> 0.
REQ-015 Samples with in_valid=0 SHALL be ignored; ch_idx SHALL hold.
REQ-016 A valid sample at ch_idx=NUM_CHANNELS-1 SHALL complete the frame; out_data SHALL update and out_valid SHALL rise on the next edge (1-cycle latency).
REQ-017 Completion of a frame SHALL leave the FSM in FILL with ch_idx=0; no new in_sof is required.
REQ-018 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 out_valid SHALL clear after an edge with out_valid&out_ready unless a frame completes that cycle.
REQ-020 Completion with out_valid&out_ready in the same cycle SHALL load the new frame; out_valid stays 1.
REQ-021 Completion with out_valid=1 and out_ready=0 SHALL drop the new frame, keep the old frame, and set overflow.
REQ-022 A valid in_sof in FILL with ch_idx!=0 SHALL discard the partial frame and restart with this sample at slot 0.
REQ-023 A valid in_sof at ch_idx=0 in FILL SHALL be normal, with no effect beyond REQ-014.
REQ-024 overflow SHALL stay set until reset.

Reset
REQ-025 Reset assertion SHALL asynchronously force state=SEEK, ch_idx=0, out_valid=0, out_data=0, overflow=0.
REQ-026 Reset mid-frame SHALL discard the partial frame; after release the block SHALL wait in SEEK for in_sof.

Configuration
REQ-027 Macro TDM_ALIGN_CHECK_EN defined: the block SHALL add output port align_err (1 bit), set sticky by the REQ-022 event and cleared only by reset.
REQ-028 TDM_ALIGN_CHECK_EN undefined: align_err SHALL be absent, and the REQ-022 resync SHALL occur silently.

Structure
REQ-029 Package tdm_pkg SHALL hold default NUM_CHANNELS/DATA_WIDTH constants, a ch_idx_t typedef of width $clog2(NUM_CHANNELS), and the SEEK/FILL state enum.
REQ-030 The wrapping channel index SHALL be a sub-module tdm_chan_counter with ports: increment enable, synchronous load-to-zero, and a last-slot flag.

Verification (NUM_CHANNELS=4, DATA_WIDTH=16)
REQ-031 Bench: after reset, send 0x11(sof),0x22,0x33,0x44 with out_ready=1 -> one cycle later out_valid=1 and out_data={0x11,0x22,0x33,0x44}, overflow=0.
REQ-032 Bench: send 0xAA,0xBB with no sof after reset -> both discarded, out_valid stays 0; then a normal sof frame is assembled correctly.
REQ-033 Bench: hold out_ready=0 and send two full frames -> the first frame is held, the second is dropped, and overflow=1.
REQ-034 Bench: send sof,0x01,0x02, then sof,0x10,0x20,0x30,0x40 -> out_data={0x10,0x20,0x30,0x40}; align_err=1 only when TDM_ALIGN_CHECK_EN is defined.
REQ-035 Bench: interleave in_valid=0 bubbles within a frame, and assert reset mid-frame -> bubbles are ignored, reset clears all outputs, and the next sof frame assembles correctly.
